keypad_scan_deb: RTL and testbench

Parametrised successor to the team's 4x4 hex keypad scanner. Drives a one-hot column strobe across a ROWS x COLS matrix. Synchronises and debounces the row returns, and rejects multi-key (ghost) patterns. Reports each debounced press as a binary key code over a valid/ready handshake to the downstream key-event consumer. Auto-repeat is not supported; each press is reported once.

---
 rtl/keypad_scan_deb.sv | 193 +++++++++++++++++++
 tb/tb_keypad_scan_deb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_deb.sv
// Matrix keypad scanner: one-hot column strobe, row synchroniser, debounce, ghost-key
// rejection and a valid/ready key-event output. Define KEY_RELEASE_EVT_EN to also report releases.
module keypad_scan_deb #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 4,
    parameter int DEB_CNT  = 3,
    parameter int CODE_W   = ($clog2(ROWS*COLS) < 1) ? 1 : $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
`ifdef KEY_RELEASE_EVT_EN
    output logic              key_release,
`endif
    output logic              multi_key
);

    localparam int DW    = $clog2(SCAN_DIV);
    localparam int DEB_W = 4;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, REPORT, HELD} state_t;

    state_t            state, state_nxt;
    logic [ROWS-1:0]   row_meta, rs, cand_row, cand_row_nxt;
    logic [DW-1:0]     dwell, dwell_nxt;
    logic [DEB_W-1:0]  deb, deb_nxt;
    logic [COLS-1:0]   col_nxt, col_rot;
    logic [CODE_W-1:0] key_code_nxt, cap_code;
    logic              key_valid_nxt, key_held_nxt, multi_key_nxt;
    logic              sample, rs_one, rs_multi, deb_done;
    int                row_idx, col_idx;
`ifdef KEY_RELEASE_EVT_EN
    logic              key_release_nxt;
`endif

    assign sample   = (dwell == DW'(SCAN_DIV - 1));
    assign rs_one   = (rs != '0) && ((rs & (rs - ROWS'(1))) == '0);
    assign rs_multi = (rs != '0) && !rs_one;
    assign col_rot  = {col[COLS-2:0], col[COLS-1]};
    assign deb_done = (deb == DEB_W'(DEB_CNT - 1));

    // Binary code of the single row bit currently seen and the column being driven.
    always_comb begin
        row_idx = 0;
        col_idx = 0;
        for (int i = 0; i < ROWS; i++) if (rs[i]) row_idx = i;
        for (int j = 0; j < COLS; j++) if (col[j]) col_idx = j;
        cap_code = CODE_W'(row_idx * COLS + col_idx);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt     = state;
        dwell_nxt     = dwell;
        deb_nxt       = deb;
        col_nxt       = col;
        cand_row_nxt  = cand_row;
        key_code_nxt  = key_code;
        key_valid_nxt = key_valid;
        key_held_nxt  = key_held;
        multi_key_nxt = 1'b0;
`ifdef KEY_RELEASE_EVT_EN
        key_release_nxt = key_release;
`endif
        if (state != REPORT) dwell_nxt = sample ? '0 : dwell + DW'(1);

        case (state)
            SCAN: if (sample) begin
                if (rs == '0) begin
                    col_nxt = col_rot;
                end else if (rs_one) begin
                    cand_row_nxt = rs;
                    key_code_nxt = cap_code;
                    if (DEB_CNT == 1) begin
                        state_nxt     = REPORT;
                        key_valid_nxt = 1'b1;
                        deb_nxt       = '0;
                    end else begin
                        state_nxt = DEBOUNCE;
                        deb_nxt   = DEB_W'(1);
                    end
                end else begin
                    multi_key_nxt = 1'b1;
                    col_nxt       = col_rot;
                end
            end
            DEBOUNCE: if (sample) begin
                multi_key_nxt = rs_multi;
                if (rs == cand_row) begin
                    if (deb_done) begin
                        state_nxt     = REPORT;
                        key_valid_nxt = 1'b1;
                        deb_nxt       = '0;
                    end else begin
                        deb_nxt = deb + DEB_W'(1);
                    end
                end else begin
                    deb_nxt   = '0;
                    col_nxt   = col_rot;
                    state_nxt = SCAN;
                end
            end
            REPORT: if (key_ready) begin
                key_valid_nxt = 1'b0;
                deb_nxt       = '0;
`ifdef KEY_RELEASE_EVT_EN
                if (key_release) begin
                    key_release_nxt = 1'b0;
                    col_nxt         = col_rot;
                    state_nxt       = SCAN;
                end else begin
                    key_held_nxt = 1'b1;
                    state_nxt    = HELD;
                end
`else
                key_held_nxt = 1'b1;
                state_nxt    = HELD;
`endif
            end
            HELD: if (sample) begin
                // Only the accepted key's row matters; other keys in this column are ignored.
                if ((rs & cand_row) == '0) begin
                    if (deb_done) begin
                        key_held_nxt = 1'b0;
                        deb_nxt      = '0;
`ifdef KEY_RELEASE_EVT_EN
                        key_valid_nxt   = 1'b1;
                        key_release_nxt = 1'b1;
                        state_nxt       = REPORT;
`else
                        col_nxt   = col_rot;
                        state_nxt = SCAN;
`endif
                    end else begin
                        deb_nxt = deb + DEB_W'(1);
                    end
                end else begin
                    deb_nxt = '0;
                end
            end
            default: begin
                state_nxt     = SCAN;
                col_nxt       = COLS'(1);
                dwell_nxt     = '0;
                deb_nxt       = '0;
                key_valid_nxt = 1'b0;
                key_held_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            row_meta  <= '0;
            rs        <= '0;
            dwell     <= '0;
            deb       <= '0;
            col       <= COLS'(1);
            cand_row  <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
`ifdef KEY_RELEASE_EVT_EN
            key_release <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            row_meta  <= row;
            rs        <= row_meta;
            state     <= state_nxt;
            dwell     <= dwell_nxt;
            deb       <= deb_nxt;
            col       <= col_nxt;
            cand_row  <= cand_row_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
            multi_key <= multi_key_nxt;
`ifdef KEY_RELEASE_EVT_EN
            key_release <= key_release_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scan_deb.sv
// Self-checking bench for keypad_scan_deb: a default 4x4 instance driven by a keypad model
// and a 2x8 instance; honours KEY_RELEASE_EVT_EN when defined.
module tb_keypad_scan_deb;

    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEB_CNT = 3, CODE_W = 4;
    localparam int R2 = 2, C2 = 8;
`ifdef KEY_RELEASE_EVT_EN
    localparam int EVT_PER_PRESS = 2;
`else
    localparam int EVT_PER_PRESS = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // 4x4 instance
    logic [ROWS-1:0]      row;
    logic [COLS-1:0]      col;
    logic [CODE_W-1:0]    key_code;
    logic                 key_valid, key_held, multi_key;
    logic                 key_ready = 1'b0;
    // 2x8 instance
    logic [R2-1:0]        row2;
    logic [C2-1:0]        col2;
    logic [3:0]           key_code2;
    logic                 key_valid2, key_held2, multi_key2;
    logic                 key_ready2 = 1'b0;
`ifdef KEY_RELEASE_EVT_EN
    logic                 key_release, key_release2;
    logic                 last_rel;
`endif

    keypad_scan_deb #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT), .CODE_W(CODE_W)) u_dut (
        .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held),
`ifdef KEY_RELEASE_EVT_EN
        .key_release(key_release),
`endif
        .multi_key(multi_key)
    );

    keypad_scan_deb #(.ROWS(R2), .COLS(C2), .SCAN_DIV(4), .DEB_CNT(3), .CODE_W(4)) u_dut2 (
        .clk(clk), .reset(reset), .row(row2), .col(col2), .key_code(key_code2),
        .key_valid(key_valid2), .key_ready(key_ready2), .key_held(key_held2),
`ifdef KEY_RELEASE_EVT_EN
        .key_release(key_release2),
`endif
        .multi_key(multi_key2)
    );

    // Keypad model: a pressed key shorts its row to its column while that column is driven.
    logic                 kp_mode = 1'b1;
    logic [ROWS-1:0]      raw_row = '0;
    logic [ROWS*COLS-1:0] pressed = '0;
    logic [R2*C2-1:0]     pressed2 = '0;

    always_comb begin
        row = raw_row;
        if (kp_mode) begin
            row = '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (pressed[r*COLS+c] && col[c]) row[r] = 1'b1;
        end
    end

    always_comb begin
        row2 = '0;
        for (int r = 0; r < R2; r++)
            for (int c = 0; c < C2; c++)
                if (pressed2[r*C2+c] && col2[c]) row2[r] = 1'b1;
    end

    // Event monitors, sampled just after each rising edge.
    int valid_rises = 0, col_changes = 0, multi_wide = 0;
    logic valid_q = 1'b0, multi_q = 1'b0;
    logic [COLS-1:0] col_q = '0;
    always @(posedge clk) begin
        #1;
        if (key_valid && !valid_q) valid_rises++;
        if (multi_key && multi_q) multi_wide++;
        if (col != col_q) col_changes++;
        valid_q = key_valid;
        multi_q = multi_key;
        col_q   = col;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (key_valid !== 1'b1 && k < budget) begin tick(); k++; end
        check({name, "_valid_seen"}, key_valid, 1);
    endtask

    // Consumes one event from the 4x4 instance after holding off key_ready for `stall` cycles.
    task automatic take_event(input string name, input int stall, output int code);
        bit steady;
        steady = 1'b1;
        wait_valid(name, 400);
        code = int'(key_code);
`ifdef KEY_RELEASE_EVT_EN
        last_rel = key_release;
`endif
        for (int i = 0; i < stall; i++) begin
            tick();
            if (key_valid !== 1'b1 || int'(key_code) != code) steady = 1'b0;
        end
        if (stall > 0) check({name, "_stall_stable"}, steady, 1);
        key_ready = 1'b1; tick(); key_ready = 1'b0;
        check({name, "_valid_drop"}, key_valid, 0);
    endtask

    task automatic release_key(input string name, input int exp_code);
        int k = 0;
`ifdef KEY_RELEASE_EVT_EN
        int rcode;
`endif
        pressed = '0;
        while (key_held !== 1'b0 && k < 200) begin tick(); k++; end
        check({name, "_released"}, key_held, 0);
`ifdef KEY_RELEASE_EVT_EN
        take_event({name, "_relevt"}, 0, rcode);
        check({name, "_rel_code"}, rcode, exp_code);
        check({name, "_rel_flag"}, last_rel, 1);
`endif
    endtask

    task automatic press_and_report(input string name, input int r, input int c,
                                    input int stall, input int exp_code);
        int code;
        pressed = '0;
        pressed[r*COLS+c] = 1'b1;
        take_event(name, stall, code);
        check({name, "_code"}, code, exp_code);
`ifdef KEY_RELEASE_EVT_EN
        check({name, "_press_flag"}, last_rel, 0);
`endif
        check({name, "_held"}, key_held, 1);
        release_key(name, exp_code);
        tick(3);
    endtask

    typedef struct { int r; int c; int stall; int code; } vec_t;
    vec_t vecs[5];
    int   exp_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cbase, mwbase, k, lat, mk, nb;
        bit steady, mk_col_ok;

        vecs[0] = '{0, 0, 0, 0};
        vecs[1] = '{3, 3, 2, 15};
        vecs[2] = '{1, 2, 7, 6};
        vecs[3] = '{0, 3, 0, 3};
        vecs[4] = '{2, 0, 4, 8};

        // Reset state
        tick(2);
        check("rst_col", col, 4'b0001);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_multi", multi_key, 0);
        check("rst_code", key_code, 0);
        check("rst_col2", col2, 8'b0000_0001);
`ifdef KEY_RELEASE_EVT_EN
        check("rst_release", key_release, 0);
`endif
        pressed = '0;
        pressed[2*COLS+1] = 1'b1;
        #2 reset = 1'b1;

        // Test 1: key (row 2, col 1) -> code 9, exact latency, single event, held until release
        base = valid_rises;
        k = 0;
        while (col !== 4'b0010 && k < 100) begin tick(); k++; end
        check("t1_reach_col1", col, 4'b0010);
        lat = 0;
        while (key_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
        check("t1_latency", lat, DEB_CNT*SCAN_DIV);
        check("t1_code", key_code, 9);
        key_ready = 1'b1; tick(); key_ready = 1'b0;
        check("t1_valid_drop", key_valid, 0);
        check("t1_held", key_held, 1);
        tick(40);
        check("t1_one_event", valid_rises - base, 1);
        check("t1_col_frozen", col, 4'b0010);
        check("t1_held_still", key_held, 1);
        release_key("t1", 9);
        check("t1_col_after_release", col, 4'b0100);
        tick(3);

        // Table-driven presses
        for (int i = 0; i < 5; i++)
            press_and_report($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].stall, vecs[i].code);

        // Test 2: bounce alternating every sample never qualifies; then a stable press
        base = valid_rises; cbase = col_changes; mwbase = multi_wide;
        kp_mode = 1'b0; pressed = '0;
        for (int i = 0; i < 10; i++) begin
            raw_row = 4'b0100; tick(SCAN_DIV);
            raw_row = 4'b0000; tick(SCAN_DIV);
        end
        check("t2_no_event", valid_rises - base, 0);
        check("t2_col_moving", (col_changes - cbase) >= 5, 1);
        kp_mode = 1'b1;
        press_and_report("t2_stable", 2, 3, 0, 11);
        check("t2_event_count", valid_rises - base, EVT_PER_PRESS);

        // Test 3: consumer stalls 20 cycles in REPORT
        pressed = '0;
        pressed[3*COLS+2] = 1'b1;
        wait_valid("t3", 200);
        steady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (key_valid !== 1'b1 || key_code !== 4'd14 || col !== 4'b0100) steady = 1'b0;
            tick();
        end
        check("t3_stall_stable", steady, 1);
        check("t3_code", key_code, 14);
        key_ready = 1'b1; tick(); key_ready = 1'b0;
        check("t3_valid_drop", key_valid, 0);
        check("t3_held", key_held, 1);
        release_key("t3", 14);
        tick(3);

        // Test 4: two keys in column 1 give rows 0011 -> ghost pulse, column advances
        base = valid_rises; mwbase = multi_wide; mk = 0; mk_col_ok = 1'b1;
        pressed = '0;
        pressed[0*COLS+1] = 1'b1;
        pressed[1*COLS+1] = 1'b1;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (multi_key === 1'b1) begin
                mk++;
                if (col !== 4'b0100) mk_col_ok = 1'b0;
            end
        end
        check("t4_multi_pulses", mk >= 2, 1);
        check("t4_col_advanced", mk_col_ok, 1);
        check("t4_no_event", valid_rises - base, 0);
        check("t4_pulse_width", multi_wide - mwbase, 0);
        pressed = '0;
        tick(8);

        // Randomised presses with contact bounce against an ordered event queue
        for (int i = 0; i < 12; i++) begin
            int r, c, st;
            r  = $urandom_range(ROWS-1);
            c  = $urandom_range(COLS-1);
            st = $urandom_range(6);
            exp_q.push_back(r*COLS + c);
            nb = $urandom_range(4);
            for (int j = 0; j < nb; j++) begin
                pressed[r*COLS+c] = 1'b1; tick();
                pressed = '0; tick($urandom_range(2, 1));
            end
            press_and_report($sformatf("rnd%0d", i), r, c, st, exp_q.pop_front());
        end

        // Test 5: asynchronous reset while an event is pending
        pressed = '0;
        pressed[1*COLS+0] = 1'b1;
        wait_valid("t5", 200);
        tick();
        #2 reset = 1'b0;
        #1;
        check("t5_async_valid", key_valid, 0);
        check("t5_async_col", col, 4'b0001);
        check("t5_async_held", key_held, 0);
        pressed = '0;
        tick();
        #2 reset = 1'b1;
        tick(3);
        check("t5_restart_col0", col, 4'b0001);
        tick();
        check("t5_restart_col1", col, 4'b0010);
        check("t5_discarded", key_valid, 0);

        // Test 6: 2x8 instance, row 1 / col 7 -> code 15
        pressed2 = '0;
        pressed2[1*C2+7] = 1'b1;
        k = 0;
        while (key_valid2 !== 1'b1 && k < 400) begin tick(); k++; end
        check("t6_valid", key_valid2, 1);
        check("t6_code", key_code2, 15);
`ifdef KEY_RELEASE_EVT_EN
        check("t6_press_flag", key_release2, 0);
`endif
        key_ready2 = 1'b1; tick(); key_ready2 = 1'b0;
        check("t6_valid_drop", key_valid2, 0);
        check("t6_held", key_held2, 1);
        pressed2 = '0;
        k = 0;
        while (key_held2 !== 1'b0 && k < 400) begin tick(); k++; end
        check("t6_released", key_held2, 0);
`ifdef KEY_RELEASE_EVT_EN
        k = 0;
        while (key_valid2 !== 1'b1 && k < 400) begin tick(); k++; end
        check("t6_rel_valid", key_valid2, 1);
        check("t6_rel_code", key_code2, 15);
        check("t6_rel_flag", key_release2, 1);
        key_ready2 = 1'b1; tick(); key_ready2 = 1'b0;
        check("t6_rel_drop", key_valid2, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
